// File: rtl/shift_arbiter_2_pkg.sv
// Shared widths, result-register FSM encoding and job record for shift_arbiter_2.
package shift_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAG_W   = 4;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } fsm_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MAG_W-1:0]  mag;
  } job_t;

endpackage

// File: rtl/shift_arbiter_2_if.sv
// Requester and result handshake bundle for shift_arbiter_2.
interface shift_arbiter_2_if;

  logic [shift_arb_pkg::NUM_REQ-1:0] Req_Valid;
  logic [shift_arb_pkg::NUM_REQ-1:0] Req_Ready;
  logic [shift_arb_pkg::DATA_W-1:0]  Req0_Data;
  logic [shift_arb_pkg::DATA_W-1:0]  Req1_Data;
  logic [shift_arb_pkg::MAG_W-1:0]   Req0_Mag;
  logic [shift_arb_pkg::MAG_W-1:0]   Req1_Mag;
  logic                              Res_Valid;
  logic                              Res_Ready;
  logic [shift_arb_pkg::DATA_W-1:0]  Res_Data;
  logic                              Res_Id;

  // Requesters and result consumer side.
  modport master (
    output Req_Valid, Req0_Data, Req1_Data, Req0_Mag, Req1_Mag, Res_Ready,
    input  Req_Ready, Res_Valid, Res_Data, Res_Id
  );

  // Arbiter side.
  modport slave (
    input  Req_Valid, Req0_Data, Req1_Data, Req0_Mag, Req1_Mag, Res_Ready,
    output Req_Ready, Res_Valid, Res_Data, Res_Id
  );

endinterface

// File: rtl/barrel_shr_16.sv
// 16-bit logical right barrel shifter, zero fill from the MSB side.
module barrel_shr_16 (
  input  logic [15:0] din,
  input  logic [3:0]  shamt,
  output logic [15:0] dout
);

  logic [15:0] s0, s1, s2;

  always_comb begin
    s0   = shamt[0] ? {1'b0, din[15:1]} : din;
    s1   = shamt[1] ? {2'b0, s0[15:2]}  : s0;
    s2   = shamt[2] ? {4'b0, s1[15:4]}  : s1;
    dout = shamt[3] ? {8'b0, s2[15:8]}  : s2;
  end

endmodule

// File: rtl/shift_arbiter_2_rr_arb_2.sv
// Two-way round-robin grant with its Last_Grant register; swappable for an N-way arbiter.
module rr_arb_2
  import shift_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               xfer,
  output logic [NUM_REQ-1:0] grant
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    last_grant_d = xfer ? grant[1] : last_grant_q;
  end

  // Resets to 1 so requester 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/shift_arbiter_2.sv
// Round-robin sequencer sharing one right barrel shifter between two requesters,
// with a one-entry result register drained over a valid/ready port.
module shift_arbiter_2
  import shift_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  shift_arbiter_2_if.slave bus,
  output logic [CNT_W-1:0] Acc_Cnt0,
  output logic [CNT_W-1:0] Acc_Cnt1
);

  fsm_e              state_q, state_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_id_q, res_id_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] req_ready;
  logic               res_valid;
  logic               can_accept;
  logic               xfer;
  job_t               sel_job;
  logic [DATA_W-1:0]  shifted;

  rr_arb_2 u_rr_arb (
    .clk       (Clk),
    .rst       (Rst),
    .req_valid (bus.Req_Valid),
    .xfer      (xfer),
    .grant     (grant)
  );

  barrel_shr_16 u_shifter (
    .din   (sel_job.data),
    .shamt (sel_job.mag),
    .dout  (shifted)
  );

  always_comb begin
    sel_job    = grant[1] ? job_t'{data: bus.Req1_Data, mag: bus.Req1_Mag}
                          : job_t'{data: bus.Req0_Data, mag: bus.Req0_Mag};
    res_valid  = (state_q == ST_FULL);
    can_accept = (state_q == ST_EMPTY) | (res_valid & bus.Res_Ready);
    req_ready  = (can_accept && !Rst) ? grant : '0;
    xfer       = |(bus.Req_Valid & req_ready);

    state_d    = state_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;

    // A transfer while draining overwrites the register in place, no bubble.
    if (xfer) begin
      state_d    = ST_FULL;
      res_data_d = shifted;
      res_id_d   = grant[1];
      if (grant[0] && cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
      if (grant[1] && cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
    end else if (res_valid && bus.Res_Ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_EMPTY;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign bus.Req_Ready = req_ready;
  assign bus.Res_Valid = res_valid;
  assign bus.Res_Data  = res_data_q;
  assign bus.Res_Id    = res_id_q;
  assign Acc_Cnt0      = cnt0_q;
  assign Acc_Cnt1      = cnt1_q;

endmodule

// File: tb/tb_shift_arbiter_2.sv
// Directed self-checking bench for shift_arbiter_2.
module tb_shift_arbiter_2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] Acc_Cnt0, Acc_Cnt1;
  int         checks = 0;
  int         errors = 0;

  shift_arbiter_2_if bus ();

  shift_arbiter_2 #(.CNT_W(8)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .bus      (bus),
    .Acc_Cnt0 (Acc_Cnt0),
    .Acc_Cnt1 (Acc_Cnt1)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [15:0] d, input logic id);
    chk({tag, "_valid"}, 32'(bus.Res_Valid), 32'(v));
    chk({tag, "_data"},  32'(bus.Res_Data),  32'(d));
    chk({tag, "_id"},    32'(bus.Res_Id),    32'(id));
  endtask

  initial begin
    bus.Req_Valid = 2'b00;
    bus.Req0_Data = '0; bus.Req0_Mag = '0;
    bus.Req1_Data = '0; bus.Req1_Mag = '0;
    bus.Res_Ready = 1'b0;

    // Initial reset with a job presented: must not be accepted.
    bus.Req_Valid = 2'b01;
    @(negedge Clk);
    chk("rst_ready", 32'(bus.Req_Ready), 32'h0);
    step(); step();
    @(negedge Clk);
    chk_res("rst", 1'b0, 16'h0000, 1'b0);
    chk("rst_cnt0", 32'(Acc_Cnt0), 32'd0);
    chk("rst_cnt1", 32'(Acc_Cnt1), 32'd0);
    step();
    Rst = 1'b0;

    // Contention: grants 0,1,0,1 starting from requester 0.
    bus.Req_Valid = 2'b11;
    bus.Req0_Data = 16'h8000; bus.Req0_Mag = 4'd15;
    bus.Req1_Data = 16'hFFFF; bus.Req1_Mag = 4'd8;
    bus.Res_Ready = 1'b1;
    @(negedge Clk);
    chk("cont0_ready", 32'(bus.Req_Ready), 32'h1);
    step();
    @(negedge Clk);
    chk_res("cont0", 1'b1, 16'h0001, 1'b0);
    chk("cont1_ready", 32'(bus.Req_Ready), 32'h2);
    step();
    @(negedge Clk);
    chk_res("cont1", 1'b1, 16'h00FF, 1'b1);
    chk("cont2_ready", 32'(bus.Req_Ready), 32'h1);
    step();
    @(negedge Clk);
    chk_res("cont2", 1'b1, 16'h0001, 1'b0);
    chk("cont3_ready", 32'(bus.Req_Ready), 32'h2);
    step();
    bus.Req_Valid = 2'b00;
    @(negedge Clk);
    chk_res("cont3", 1'b1, 16'h00FF, 1'b1);
    chk("cont_idle_ready", 32'(bus.Req_Ready), 32'h0);
    chk("cont_cnt0", 32'(Acc_Cnt0), 32'd2);
    chk("cont_cnt1", 32'(Acc_Cnt1), 32'd2);
    step();
    @(negedge Clk);
    chk("drain_valid", 32'(bus.Res_Valid), 32'h0);

    // Single job from requester 0.
    step();
    bus.Req_Valid = 2'b01;
    bus.Req0_Data = 16'hF0F0; bus.Req0_Mag = 4'd4;
    @(negedge Clk);
    chk("single_ready", 32'(bus.Req_Ready), 32'h1);
    step();

    // Backpressure: register FULL, consumer stalled, requester 1 waiting.
    bus.Res_Ready = 1'b0;
    bus.Req_Valid = 2'b10;
    bus.Req1_Data = 16'h1234; bus.Req1_Mag = 4'd4;
    @(negedge Clk);
    chk_res("single", 1'b1, 16'h0F0F, 1'b0);
    chk("single_cnt0", 32'(Acc_Cnt0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(bus.Req_Ready), 32'h0);
      chk_res("bp_hold", 1'b1, 16'h0F0F, 1'b0);
      step();
      @(negedge Clk);
    end
    bus.Res_Ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.Req_Ready), 32'h2);
    step();
    bus.Req1_Data = 16'hFF00; bus.Req1_Mag = 4'd8;
    @(negedge Clk);
    chk_res("bp_replace", 1'b1, 16'h0123, 1'b1);
    chk("bp_next_ready", 32'(bus.Req_Ready), 32'h2);
    step();

    // Magnitude bounds.
    bus.Req_Valid = 2'b01;
    bus.Req0_Data = 16'hA5A5; bus.Req0_Mag = 4'd0;
    @(negedge Clk);
    chk_res("bp_next", 1'b1, 16'h00FF, 1'b1);
    chk("bp_cnt1", 32'(Acc_Cnt1), 32'd4);
    step();
    bus.Req0_Data = 16'h7FFF; bus.Req0_Mag = 4'd15;
    @(negedge Clk);
    chk_res("mag0", 1'b1, 16'hA5A5, 1'b0);
    step();
    bus.Req_Valid = 2'b00;
    bus.Res_Ready = 1'b0;
    @(negedge Clk);
    chk_res("mag15", 1'b1, 16'h0000, 1'b0);

    // Reset mid-FULL with a job presented during reset.
    step();
    Rst = 1'b1;
    bus.Req_Valid = 2'b10;
    @(negedge Clk);
    chk("rst2_ready", 32'(bus.Req_Ready), 32'h0);
    step(); step();
    Rst = 1'b0;
    bus.Req_Valid = 2'b11;
    bus.Req0_Data = 16'h00F0; bus.Req0_Mag = 4'd4;
    @(negedge Clk);
    chk_res("rst2", 1'b0, 16'h0000, 1'b0);
    chk("rst2_cnt0", 32'(Acc_Cnt0), 32'd0);
    chk("rst2_cnt1", 32'(Acc_Cnt1), 32'd0);
    chk("rst2_contest", 32'(bus.Req_Ready), 32'h1);
    step();
    bus.Req_Valid = 2'b01;
    bus.Res_Ready = 1'b1;
    @(negedge Clk);
    chk_res("rst2_first", 1'b1, 16'h000F, 1'b0);

    // Saturation: 300 more requester-0 transfers.
    for (int i = 0; i < 300; i++) step();
    bus.Req_Valid = 2'b00;
    @(negedge Clk);
    chk("sat_cnt0", 32'(Acc_Cnt0), 32'd255);
    chk("sat_cnt1", 32'(Acc_Cnt1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter_2.md
# shift_arbiter_2

Two-requester round-robin arbiter and sequencer for the shared 16-bit logical right barrel shifter. It accepts shift jobs (data plus a 4-bit magnitude) from two independent valid/ready requesters and grants one per cycle to the single shifter instance. The shifted word is captured with the winner's ID in a one-entry result register, which drains over a valid/ready output port. The block sits between the LFSR/associative-memory control logic and the shifter datapath, so both clients share one shifter with no structural hazard.

## Interface
Parameters:
- CNT_W, 8: width of the per-requester saturating accept counters.

Ports:
- Clk  input  1  rising-edge clock, the only clock.
- Rst  input  1  synchronous, active-high reset.
- Req_Valid  input  2  bit i high means requester i presents a job.
- Req_Ready  output  2  bit i high means requester i's job is accepted this cycle. At most one bit is high.
- Req0_Data, Req1_Data  input  16  words to shift.
- Req0_Mag, Req1_Mag  input  4  right-shift magnitudes, 0..15.
- Res_Valid  output  1  result register holds a result.
- Res_Ready  input  1  consumer takes the result this cycle.
- Res_Data  output  16  shifted word. Zero-filled from the MSB side.
- Res_Id  output  1  requester that produced Res_Data.
- Acc_Cnt0, Acc_Cnt1  output  CNT_W  saturating count of accepted jobs per requester.

## Operation
Result-register FSM states:
- EMPTY: the register holds nothing.
- FULL: the register holds one result.

Accept rule:
- Can_Accept = (state == EMPTY) | (Res_Valid & Res_Ready).
- Req_Ready[i] = Can_Accept & Grant[i].
- Req_Ready is allowed to depend combinationally on Req_Valid and Res_Ready.
- A job transfers when Req_Valid[i] & Req_Ready[i].

Grant (round-robin):
- Only one valid: grant it.
- Both valid: grant the requester that is not Last_Grant.
- Neither valid: no grant.
- Last_Grant updates only on a transfer.
- Last_Grant resets to 1, so requester 0 wins the first contest.

Datapath:
- The granted Data/Mag is muxed into the shifter.
- On transfer: Res_Data <= Data >> Mag (logical, zero fill) and Res_Id <= winner.
- Mag = 0 passes the word unchanged. Mag = 15 leaves only the original bit 15, in bit 0.

State transitions:
- EMPTY to FULL on a transfer.
- FULL to EMPTY on drain (Res_Ready) with no transfer.
- FULL stays FULL on simultaneous drain and transfer. The new result replaces the old one in the same edge, with no bubble.
- FULL with no drain: Req_Ready = 0, and the register and its ID hold stable.

Counters:
- Acc_CntN increments on each transfer from requester N.
- They saturate at 2^CNT_W-1 and do not wrap.

Reset (synchronous):
- Applies on any edge with Rst high, including mid-operation.
- State <= EMPTY, Res_Valid = 0, Res_Data = 0, Res_Id = 0, Acc_Cnt* = 0, Last_Grant = 1.
- A job presented during the Rst cycle is dropped. Req_Ready is 0 while Rst is high.

## Timing
- Latency: a job accepted on edge N has Res_Valid high after edge N, i.e. visible in cycle N+1.
- Throughput: one job per cycle with Res_Ready held high.
- Alternation: with both requesters continuously valid, grants alternate 0,1,0,1 and starvation is impossible.
- Valid stability: Res_Valid, once high, stays high with Res_Data/Res_Id stable until the cycle in which Res_Ready is sampled high.
- Requesters must hold Data/Mag stable while Valid is high and Ready is low. Requesters are not required to wait for Ready before asserting Valid.

## Structure
- Package shift_arb_pkg holds:
  - NUM_REQ = 2, DATA_W = 16, MAG_W = 4.
  - The two-state FSM enum (ST_EMPTY, ST_FULL).
  - The job struct {data, mag}.
- Sub-module rr_arb_2: a combinational grant from Req_Valid and Last_Grant, plus the Last_Grant register. It is kept separate so a later N-way arbiter can replace it.
- The top level instantiates the team's existing 16-bit right barrel shifter unchanged. No shifter logic is duplicated.

## Test plan
- Reset: Rst held 2 cycles mid-FULL with Res_Ready = 0 -> Res_Valid = 0, Acc_Cnt0/1 = 0, Res_Data = 0; the next contest is won by requester 0.
- Single job: Req0 = 0xF0F0, Mag = 4, Res_Ready = 1 -> Req_Ready = 2'b01 in the same cycle; the next cycle Res_Valid = 1, Res_Data = 0x0F0F, Res_Id = 0.
- Contention: both requesters valid for 4 cycles (Req0 = 0x8000/15, Req1 = 0xFFFF/8), Res_Ready = 1 -> results 0x0001 (id 0), 0x00FF (id 1), 0x0001 (id 0), 0x00FF (id 1) on consecutive cycles.
- Backpressure: Res_Ready = 0 with the register FULL and Req1 valid for 3 cycles -> Req_Ready = 0 and Res_Data stable. Raising Res_Ready drains the old result and accepts Req1 on the same edge; the next result follows with no bubble.
- Magnitude bounds: Mag = 0 on 0xA5A5 -> 0xA5A5. Mag = 15 on 0x7FFF -> 0x0000.
- Saturation: with CNT_W = 8, 300 Req0 transfers -> Acc_Cnt0 = 255, Acc_Cnt1 = 0.
